// File: rtl/selector_n1_pipe_if.sv
// Channel-side and output-side handshake bundle for the N:1 pipelined selector.
// The slave modport is the selector's view; master is the driver/consumer's view.
interface selector_n1_pipe_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned N     = 8
);
    localparam int unsigned SW = $clog2(N);

    logic [N*WIDTH-1:0] iC;
    logic [N-1:0]       iValid;
    logic [N-1:0]       oReady;
    logic [SW-1:0]      iS;
    logic               iMode;
    logic [WIDTH-1:0]   oZ;
    logic [SW-1:0]      oSrc;
    logic               oValid;
    logic               iReady;

    modport master (
        output iC, iValid, iS, iMode, iReady,
        input  oReady, oZ, oSrc, oValid
    );

    modport slave (
        input  iC, iValid, iS, iMode, iReady,
        output oReady, oZ, oSrc, oValid
    );
endinterface

// File: rtl/selector_n1_pipe.sv
// N:1 channel selector with a single registered output stage; fixed-select or
// round-robin arbitration, one word per cycle, stalls when downstream is not ready.
module selector_n1_pipe #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned N     = 8
) (
    input logic                clk,
    input logic                rst,
    selector_n1_pipe_if.slave  bus
);
    localparam int unsigned SW = $clog2(N);
    localparam logic [SW:0] NumCh = N[SW:0];

    logic             load;
    logic             gnt;
    logic [SW-1:0]    gnt_idx;
    logic [WIDTH-1:0] gnt_data;
    logic [N-1:0]     ready;
    logic [2*N-1:0]   rot;
    logic [SW:0]      sum;
    logic [SW:0]      inc;

    logic [SW-1:0]    ptr_q, ptr_d;
    logic [WIDTH-1:0] oz_q;
    logic [SW-1:0]    osrc_q;
    logic             ovalid_q;

    always_comb begin
        load    = !ovalid_q || bus.iReady;
        gnt     = 1'b0;
        gnt_idx = '0;
        sum     = '0;
        // Doubling the valid vector lets a plain shift implement the wrap-around search.
        rot     = {bus.iValid, bus.iValid} >> ptr_q;
        if (bus.iMode) begin
            for (int off = 0; off < N; off++) begin
                if (!gnt && rot[off]) begin
                    gnt = 1'b1;
                    sum = {1'b0, ptr_q} + (SW + 1)'(off);
                    if (sum >= NumCh) begin
                        sum = sum - NumCh;
                    end
                    gnt_idx = sum[SW-1:0];
                end
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                if (bus.iS == SW'(k) && bus.iValid[k]) begin
                    gnt     = 1'b1;
                    gnt_idx = SW'(k);
                end
            end
        end
        gnt = gnt && load && !rst;
    end

    always_comb begin
        ready    = '0;
        gnt_data = '0;
        for (int k = 0; k < N; k++) begin
            ready[k] = gnt && (gnt_idx == SW'(k));
            if (gnt_idx == SW'(k)) begin
                gnt_data = bus.iC[k*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        inc   = {1'b0, gnt_idx} + 1'b1;
        if (gnt && bus.iMode) begin
            ptr_d = (inc == NumCh) ? '0 : inc[SW-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q    <= '0;
            oz_q     <= '0;
            osrc_q   <= '0;
            ovalid_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
            if (gnt) begin
                oz_q     <= gnt_data;
                osrc_q   <= gnt_idx;
                ovalid_q <= 1'b1;
            end else if (load) begin
                ovalid_q <= 1'b0;
            end
        end
    end

    assign bus.oReady = ready;
    assign bus.oZ     = oz_q;
    assign bus.oSrc   = osrc_q;
    assign bus.oValid = ovalid_q;
endmodule

// File: tb/tb_selector_n1_pipe.sv
// Self-checking bench: vector table plus scoreboard model for N=8, hand sequence for N=6.
module tb_selector_n1_pipe;
    logic clk = 1'b0;
    logic rst;
    logic rst6;
    always #5 clk = ~clk;

    selector_n1_pipe_if #(.WIDTH(32), .N(8)) bus8 ();
    selector_n1_pipe_if #(.WIDTH(32), .N(6)) bus6 ();

    selector_n1_pipe #(.WIDTH(32), .N(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
    selector_n1_pipe #(.WIDTH(32), .N(6)) dut6 (.clk(clk), .rst(rst6), .bus(bus6));

    typedef struct packed {
        logic [31:0] z;
        logic [2:0]  src;
    } sb_t;

    typedef struct {
        logic       r;
        logic       mode;
        logic [2:0] s;
        logic [7:0] v;
        logic       rdy;
        logic [7:0] exp_rdy;
    } vec_t;

    sb_t  sb[$];
    vec_t tbl[18];

    int n_cmp  = 0;
    int n_fail = 0;

    int          m_ptr = 0;
    logic        m_ov  = 1'b0;
    logic [31:0] m_z   = '0;
    logic [2:0]  m_src = '0;
    logic        force_c5 = 1'b0;
    logic [255:0] c8;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle on the N=8 instance, checked against the bench's own model.
    task automatic step(input logic r, input logic mode, input logic [2:0] s,
                        input logic [7:0] v, input logic rdy,
                        input logic use_exp, input logic [7:0] exp_rdy);
        logic       g;
        int         idx;
        logic       ld;
        logic [7:0] onehot;
        sb_t        e;
        for (int k = 0; k < 8; k++) c8[k*32 +: 32] = $urandom();
        if (force_c5) c8[5*32 +: 32] = 32'hDEAD_BEEF;
        rst          = r;
        bus8.iMode   = mode;
        bus8.iS      = s;
        bus8.iValid  = v;
        bus8.iReady  = rdy;
        bus8.iC      = c8;

        ld  = !m_ov || rdy;
        g   = 1'b0;
        idx = 0;
        if (!r && ld) begin
            if (mode) begin
                for (int o = 0; o < 8; o++) begin
                    int j;
                    j = (m_ptr + o) % 8;
                    if (!g && v[j]) begin
                        g   = 1'b1;
                        idx = j;
                    end
                end
            end else if (v[s]) begin
                g   = 1'b1;
                idx = int'(s);
            end
        end
        onehot = g ? (8'd1 << idx) : 8'd0;
        if (g) sb.push_back({c8[idx*32 +: 32], 3'(idx)});

        #4;
        check("oReady", {56'd0, bus8.oReady}, {56'd0, onehot});
        if (use_exp) check("oReady_tbl", {56'd0, bus8.oReady}, {56'd0, exp_rdy});

        @(posedge clk);
        #1;
        if (r) begin
            m_ov  = 1'b0;
            m_z   = '0;
            m_src = '0;
            m_ptr = 0;
        end else if (g) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 64'd1, 64'd0);
            end else begin
                e     = sb.pop_front();
                m_z   = e.z;
                m_src = e.src;
            end
            m_ov = 1'b1;
            if (mode) m_ptr = (idx + 1) % 8;
        end else if (ld) begin
            m_ov = 1'b0;
        end
        check("oValid", {63'd0, bus8.oValid}, {63'd0, m_ov});
        check("oZ", {32'd0, bus8.oZ}, {32'd0, m_z});
        check("oSrc", {61'd0, bus8.oSrc}, {61'd0, m_src});
        check("ptr", {61'd0, dut8.ptr_q}, 64'(m_ptr));
    endtask

    task automatic step6(input logic r, input logic mode, input logic [2:0] s,
                         input logic [5:0] v, input logic [5:0] exp_rdy);
        rst6        = r;
        bus6.iMode  = mode;
        bus6.iS     = s;
        bus6.iValid = v;
        bus6.iReady = 1'b1;
        for (int k = 0; k < 6; k++) bus6.iC[k*32 +: 32] = 32'h6000_0000 + 32'(k);
        #4;
        check("n6_oReady", {58'd0, bus6.oReady}, {58'd0, exp_rdy});
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst  = 1'b1;
        rst6 = 1'b1;
        bus8.iC = '0; bus8.iValid = '0; bus8.iS = '0; bus8.iMode = 1'b0; bus8.iReady = 1'b1;
        bus6.iC = '0; bus6.iValid = '0; bus6.iS = '0; bus6.iMode = 1'b0; bus6.iReady = 1'b1;

        //          r     mode  s     v       rdy   exp
        tbl[0]  = '{1'b1, 1'b0, 3'd0, 8'hFF, 1'b1, 8'h00};
        tbl[1]  = '{1'b1, 1'b0, 3'd0, 8'hFF, 1'b1, 8'h00};
        tbl[2]  = '{1'b0, 1'b0, 3'd5, 8'hFF, 1'b1, 8'h20};
        tbl[3]  = '{1'b0, 1'b1, 3'd0, 8'h85, 1'b1, 8'h01};
        tbl[4]  = '{1'b0, 1'b1, 3'd0, 8'h85, 1'b1, 8'h04};
        tbl[5]  = '{1'b0, 1'b1, 3'd0, 8'h85, 1'b1, 8'h80};
        tbl[6]  = '{1'b0, 1'b1, 3'd0, 8'h85, 1'b1, 8'h01};
        tbl[7]  = '{1'b0, 1'b1, 3'd0, 8'hFF, 1'b0, 8'h00};
        tbl[8]  = '{1'b0, 1'b1, 3'd0, 8'hFF, 1'b0, 8'h00};
        tbl[9]  = '{1'b0, 1'b1, 3'd0, 8'hFF, 1'b0, 8'h00};
        tbl[10] = '{1'b0, 1'b1, 3'd0, 8'hFF, 1'b1, 8'h02};
        tbl[11] = '{1'b0, 1'b0, 3'd3, 8'h08, 1'b1, 8'h08};
        tbl[12] = '{1'b0, 1'b0, 3'd6, 8'h00, 1'b1, 8'h00};
        tbl[13] = '{1'b0, 1'b0, 3'd4, 8'hFF, 1'b0, 8'h10};
        tbl[14] = '{1'b0, 1'b1, 3'd0, 8'hFF, 1'b1, 8'h04};
        tbl[15] = '{1'b0, 1'b1, 3'd0, 8'h03, 1'b1, 8'h01};
        tbl[16] = '{1'b0, 1'b1, 3'd0, 8'hFF, 1'b0, 8'h00};
        tbl[17] = '{1'b1, 1'b1, 3'd0, 8'hFF, 1'b0, 8'h00};

        @(posedge clk);
        #1;
        for (int i = 0; i < 18; i++) begin
            force_c5 = (i == 2);
            step(tbl[i].r, tbl[i].mode, tbl[i].s, tbl[i].v, tbl[i].rdy, 1'b1, tbl[i].exp_rdy);
            if (i == 2) begin
                check("scn1_oZ", {32'd0, bus8.oZ}, 64'hDEAD_BEEF);
                check("scn1_oSrc", {61'd0, bus8.oSrc}, 64'd5);
            end
            if (i == 6) check("scn2_ptr", {61'd0, dut8.ptr_q}, 64'd1);
            if (i == 17) begin
                check("scn5_oZ", {32'd0, bus8.oZ}, 64'd0);
                check("scn5_oValid", {63'd0, bus8.oValid}, 64'd0);
            end
        end
        force_c5 = 1'b0;
        // After reset the round-robin search restarts at channel 0, so channel 4 wins.
        step(1'b0, 1'b1, 3'd0, 8'h30, 1'b1, 1'b1, 8'h10);

        for (int i = 0; i < 300; i++) begin
            logic [7:0] v;
            v = 8'($urandom()) & 8'($urandom());
            step(($urandom_range(0, 49) == 0), 1'($urandom()), 3'($urandom()), v,
                 ($urandom_range(0, 3) != 0), 1'b0, 8'h00);
        end

        // N=6: out-of-range select grants nothing and drains the output.
        step6(1'b1, 1'b0, 3'd0, 6'h3F, 6'h00);
        check("n6_rst_oValid", {63'd0, bus6.oValid}, 64'd0);
        step6(1'b0, 1'b0, 3'd2, 6'h3F, 6'h04);
        check("n6_oValid", {63'd0, bus6.oValid}, 64'd1);
        check("n6_oSrc", {61'd0, bus6.oSrc}, 64'd2);
        check("n6_oZ", {32'd0, bus6.oZ}, 64'h6000_0002);
        step6(1'b0, 1'b0, 3'd7, 6'h3F, 6'h00);
        check("n6_s7_oValid", {63'd0, bus6.oValid}, 64'd0);
        check("n6_s7_oZ_hold", {32'd0, bus6.oZ}, 64'h6000_0002);
        step6(1'b0, 1'b0, 3'd6, 6'h3F, 6'h00);
        step6(1'b0, 1'b1, 3'd0, 6'h20, 6'h20);
        check("n6_rr_oSrc", {61'd0, bus6.oSrc}, 64'd5);
        check("n6_ptr_wrap", {61'd0, dut6.ptr_q}, 64'd0);
        step6(1'b0, 1'b1, 3'd0, 6'h3F, 6'h01);
        check("n6_ptr_after0", {61'd0, dut6.ptr_q}, 64'd1);

        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
